mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width in bits (legal: 8..64, even).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; accepted only when busy=0 and cancel=0.
REQ-005 SHALL have port op  input  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x no-op.
REQ-006 SHALL have port din1  input  WIDTH  multiplicand / dividend / mthi-mtlo source.
REQ-007 SHALL have port din2  input  WIDTH  multiplier / divisor.
REQ-008 SHALL have port cancel  input  1  pipeline flush; aborts the in-flight operation.
REQ-009 SHALL have port busy  output  1  iterative operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse; hi/lo updated on this cycle.
REQ-011 SHALL have port divByZero  output  1  one-cycle pulse with done for a div/divu with din2=0.
REQ-012 SHALL have ports hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-013 SHALL sample din1, din2, op on the accepting edge; later input changes have no effect on the result.
REQ-014 SHALL implement states IDLE, MUL, DIV, FIX; IDLE->MUL (mult/multu), IDLE->DIV (div/divu, din2!=0), MUL/DIV->FIX after WIDTH iterations, FIX->IDLE.
REQ-015 SHALL, for mult/multu, produce the 2*WIDTH-bit signed/unsigned product, upper half to hi, lower half to lo.
REQ-016 SHALL, for div/divu, write quotient to lo and remainder to hi; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-017 SHALL compute div on operand magnitudes, one quotient bit per cycle, sign correction in FIX.
REQ-018 SHALL hold busy=1 from the edge after acceptance until the edge that updates hi/lo: WIDTH+1 cycles of busy.
REQ-019 SHALL update hi/lo, clear busy and assert done on the same edge, WIDTH+1 edges after the accepting edge.
REQ-020 SHALL, for div/divu with din2=0, remain in IDLE, leave hi/lo unchanged, and pulse done and divByZero on the next edge.
REQ-021 SHALL return lo=most-negative, hi=0 for signed most-negative / -1 (no exception, wraps).
REQ-022 SHALL, for mthi/mtlo, write din1 to hi/lo on the accepting edge with no busy and no done.
REQ-023 SHALL ignore start while busy=1 (no queueing, no state change).
REQ-024 SHALL, on cancel with busy=1, return to IDLE at the next edge, hi/lo unchanged, no done.
REQ-025 SHALL give cancel priority over a simultaneous start; the start is dropped.
REQ-026 SHALL ignore op 11x: no state change, no pulse.
REQ-027 SHALL never assert done and busy in the same cycle.

Reset
REQ-028 SHALL, on rst, set hi=0, lo=0, busy=0, done=0, divByZero=0, state=IDLE at the next edge.
REQ-029 SHALL give rst priority over cancel and start; reset mid-operation discards partial results, no done.

Structure
REQ-030 SHALL place op encodings and the state enumeration in a shared package used also by the decoder.
REQ-031 SHALL instantiate one sub-module div_step: combinational restoring-division step (partial remainder, divisor -> next remainder, quotient bit), WIDTH-parametrised.
REQ-032 SHALL share one WIDTH+1-bit adder/subtractor between MUL and DIV iterations.

Verification (WIDTH=32)
REQ-033 mult din1=0xFFFFFFFD, din2=5 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFF1, done 1 cycle, busy high exactly 33 cycles.
REQ-034 multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 div 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 divu 7 / 0 with hi=0xAA, lo=0xBB -> next edge done=1, divByZero=1, hi=0xAA, lo=0xBB, busy never 1.
REQ-037 start mult, cancel at busy cycle 10, start held during busy -> busy=0 next edge, no done, hi/lo unchanged; then mthi 0x1234 -> hi=0x1234 after one edge.
REQ-038 rst at busy cycle 20 of divu -> next edge all outputs 0, IDLE; new multu 3x4 then completes with lo=12.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared op encodings, FSM states and the op decoder for the multiply/divide unit.
package mul_div_unit_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  typedef struct packed {
    logic is_mul;
    logic is_div;
    logic is_signed;
    logic is_mthi;
    logic is_mtlo;
  } dec_t;

  // Ops 11x decode to all-zero, i.e. a no-op.
  function automatic dec_t decode_op(input logic [2:0] op);
    dec_t d;
    d           = '0;
    d.is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    d.is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    d.is_signed = (op == OP_MULT) || (op == OP_DIV);
    d.is_mthi   = (op == OP_MTHI);
    d.is_mtlo   = (op == OP_MTLO);
    return d;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step built around the single WIDTH+1-bit adder/subtractor.
// In add mode the same adder serves the shift-add multiplier.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a_i,    // partial remainder with next dividend bit, or acc for mul
  input  logic [WIDTH:0]   b_i,    // divisor, or (masked) multiplicand
  input  logic             sub_i,  // 1: a-b (divide), 0: a+b (multiply)
  output logic [WIDTH:0]   sum_o,  // raw adder result
  output logic [WIDTH-1:0] rem_o,  // next partial remainder (restored on borrow)
  output logic             qbit_o  // quotient bit = no borrow
);

  logic [WIDTH+1:0] full;

  // Shared adder; carry-out in subtract mode means a >= b.
  always_comb begin
    full   = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + {{(WIDTH+1){1'b0}}, sub_i};
    sum_o  = full[WIDTH:0];
    qbit_o = full[WIDTH+1];
    rem_o  = qbit_o ? full[WIDTH-1:0] : a_i[WIDTH-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// Works on operand magnitudes, one bit per cycle, and fixes signs in FIX.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q;     // product high half / partial remainder
  logic [WIDTH-1:0] lo_acc_q;  // multiplier shifting out / dividend shifting into quotient
  logic [WIDTH-1:0] opnd_q;    // multiplicand / divisor magnitude
  logic [CW-1:0]    cnt_q;
  logic             neg_q_q;   // negate product or quotient in FIX
  logic             neg_r_q;   // negate remainder in FIX
  logic             is_div_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dbz_q;

  dec_t             dec;
  logic             accept;
  logic             last_iter;
  logic             s1, s2;
  logic [WIDTH-1:0] mag1, mag2;

  logic [WIDTH:0]   add_a, add_b, add_sum;
  logic             add_sub;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Decode, acceptance and operand magnitudes.
  always_comb begin
    dec       = decode_op(op);
    accept    = start && !busy && !cancel;
    last_iter = (cnt_q == CW'(WIDTH - 1));
    s1        = dec.is_signed && din1[WIDTH-1];
    s2        = dec.is_signed && din2[WIDTH-1];
    mag1      = s1 ? -din1 : din1;
    mag2      = s2 ? -din2 : din2;
  end

  // Route the shared adder: subtract for divide, conditional add for multiply.
  always_comb begin
    add_sub = (state_q == S_DIV);
    if (state_q == S_DIV) begin
      add_a = {acc_q, lo_acc_q[WIDTH-1]};
      add_b = {1'b0, opnd_q};
    end else begin
      add_a = {1'b0, acc_q};
      add_b = lo_acc_q[0] ? {1'b0, opnd_q} : '0;
    end
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .a_i    (add_a),
    .b_i    (add_b),
    .sub_i  (add_sub),
    .sum_o  (add_sum),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  // Sign correction of the finished magnitudes.
  always_comb begin
    prod     = {acc_q, lo_acc_q};
    prod_fix = neg_q_q ? -prod : prod;
    quo_fix  = neg_q_q ? -lo_acc_q : lo_acc_q;
    rem_fix  = neg_r_q ? -acc_q : acc_q;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; cancel aborts any busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && dec.is_mul)                  state_d = S_MUL;
        else if (accept && dec.is_div && din2 != '0) state_d = S_DIV;
      end
      S_MUL:   if (last_iter) state_d = S_FIX;
      S_DIV:   if (last_iter) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cancel && state_q != S_IDLE) state_d = S_IDLE;
  end

  // FSM outputs.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = done_q;
    divByZero = dbz_q;
    hi        = hi_q;
    lo        = lo_q;
  end

  // Datapath: operand capture, iterations, HI/LO writeback and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      lo_acc_q <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (dec.is_mthi) hi_q <= din1;
            if (dec.is_mtlo) lo_q <= din1;
            if (dec.is_div && din2 == '0) begin
              done_q <= 1'b1;
              dbz_q  <= 1'b1;
            end else if (dec.is_mul || dec.is_div) begin
              acc_q    <= '0;
              lo_acc_q <= mag1;
              opnd_q   <= mag2;
              cnt_q    <= '0;
              neg_q_q  <= s1 ^ s2;
              neg_r_q  <= s1;
              is_div_q <= dec.is_div;
            end
          end
        end
        S_MUL: begin
          acc_q    <= add_sum[WIDTH:1];
          lo_acc_q <= {add_sum[0], lo_acc_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + CW'(1);
        end
        S_DIV: begin
          acc_q    <= step_rem;
          lo_acc_q <= {lo_acc_q[WIDTH-2:0], step_qbit};
          cnt_q    <= cnt_q + CW'(1);
        end
        S_FIX: begin
          if (!cancel) begin
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit (WIDTH=32): stimulus pushes expected HI/LO,
// a monitor pops and compares on every done pulse.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, cancel;
  logic [2:0]  op;
  logic [31:0] din1, din2;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          busy_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   busy_run = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .din1      (din1),
    .din2      (din2),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and checks every done pulse against the scoreboard.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      chk("done_vs_busy", {63'd0, busy}, 64'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        e = exp_q.pop_front();
        chk("hi", {32'd0, hi}, {32'd0, e.hi});
        chk("lo", {32'd0, lo}, {32'd0, e.lo});
        chk("divByZero", {63'd0, divByZero}, {63'd0, e.dbz});
        chk("busy_cycles", 64'(busy_run), 64'(e.busy_cycles));
      end
      busy_run = 0;
    end else begin
      if (divByZero) chk("dbz_without_done", 64'd1, 64'd0);
      if (busy) busy_run++;
      else      busy_run = 0;
    end
  end

  task automatic push(input logic [31:0] h, input logic [31:0] l, input logic z, input int b);
    exp_t e;
    e.hi = h; e.lo = l; e.dbz = z; e.busy_cycles = b;
    exp_q.push_back(e);
  endtask

  // One-cycle request; operands are scrambled afterwards to prove they were captured.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; din1 = a; din2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'b111; din1 = $urandom; din2 = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'b111; din1 = '0; din2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_flags", {61'd0, busy, done, divByZero}, 64'd0);

    // Multiply / divide vectors: {op, din1, din2} -> {hi, lo}
    push(32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33); issue(3'b000, 32'hFFFFFFFD, 32'd5);          wait_done();
    push(32'hFFFFFFFE, 32'h00000001, 1'b0, 33); issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);   wait_done();
    push(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33); issue(3'b010, 32'hFFFFFFF9, 32'd2);          wait_done();
    push(32'h00000000, 32'h80000000, 1'b0, 33); issue(3'b010, 32'h80000000, 32'hFFFFFFFF);   wait_done();
    push(32'h00000002, 32'h0000000E, 1'b0, 33); issue(3'b011, 32'd100, 32'd7);              wait_done();
    push(32'hFFFFFFFF, 32'h00000003, 1'b0, 33); issue(3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE);   wait_done();
    push(32'h00000001, 32'hFFFFFFFD, 1'b0, 33); issue(3'b010, 32'd7, 32'hFFFFFFFE);          wait_done();
    push(32'h40000000, 32'h00000000, 1'b0, 33); issue(3'b000, 32'h80000000, 32'h80000000);   wait_done();

    // mthi / mtlo write on the accepting edge without busy or done
    issue(3'b100, 32'hAA, 32'd0);
    chk("mthi_hi", {32'd0, hi}, 64'hAA);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    issue(3'b101, 32'hBB, 32'd0);
    chk("mtlo_lo", {32'd0, lo}, 64'hBB);

    // divide by zero: immediate done+divByZero, HI/LO untouched
    push(32'hAA, 32'hBB, 1'b1, 0); issue(3'b011, 32'd7, 32'd0);
    @(negedge clk);
    chk("dbz_busy", {63'd0, busy}, 64'd0);
    wait_done();

    // no-op 11x
    issue(3'b110, 32'h55, 32'h66);
    @(negedge clk);
    chk("noop_busy", {63'd0, busy}, 64'd0);
    chk("noop_hilo", {hi, lo}, {32'hAA, 32'hBB});

    // cancel at busy cycle 10 with start held throughout
    @(negedge clk);
    start = 1'b1; op = 3'b000; din1 = 32'd9; din2 = 32'd9;
    repeat (10) @(negedge clk);
    chk("cancel_busy_before", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0; start = 1'b0; op = 3'b111;
    @(negedge clk);
    chk("cancel_busy_after", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("cancel_hilo", {hi, lo}, {32'hAA, 32'hBB});
    issue(3'b100, 32'h1234, 32'd0);
    chk("mthi_after_cancel", {32'd0, hi}, 64'h1234);

    // reset at busy cycle 20 of a divu
    issue(3'b011, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    chk("rst_busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    chk("rst_mid_flags", {61'd0, busy, done, divByZero}, 64'd0);
    push(32'd0, 32'd12, 1'b0, 33); issue(3'b001, 32'd3, 32'd4); wait_done();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
